icache: RTL
===========

ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter ICACHE_IDX_W, default 8, index bits; 2^ICACHE_IDX_W direct-mapped lines of one 32-bit word each.
REQ-002 Parameter ADDR_W, default 32, byte-address width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 rdy  input  1  global enable; low = hold all state.
REQ-006 if_valid  input  1  fetch unit requests an instruction.
REQ-007 if_pc  input  32  fetch byte address, word-aligned.
REQ-008 inst_valid  output  1  one-cycle pulse; inst_out/inst_pc valid.
REQ-009 inst_out  output  32  fetched instruction.
REQ-010 inst_pc  output  32  address of inst_out.
REQ-011 mem_req  output  1  to memory controller instruction port; miss fetch pending.
REQ-012 mem_addr  output  32  miss fetch address.
REQ-013 mem_done  input  1  one-cycle pulse from memory controller; mem_inst valid.
REQ-014 mem_inst  input  32  fetched word, little-endian assembled.
REQ-015 jump_flag  input  1  pipeline flush.

Function
REQ-016 Address split: offset = if_pc[1:0] (ignored), index = if_pc[ICACHE_IDX_W+1:2], tag = if_pc[31:ICACHE_IDX_W+2].
REQ-017 Storage per line: valid bit, tag, 32-bit data; hit = valid[index] and tag match.
REQ-018 FSM states: IDLE, MISS.
REQ-019 IDLE, if_valid, hit, no jump_flag: next edge inst_valid=1, inst_out=data[index], inst_pc=if_pc; stay IDLE (1-cycle hit latency).
REQ-020 IDLE, if_valid, miss, no jump_flag: next edge mem_req=1, mem_addr=if_pc, latch if_pc; go MISS; inst_valid=0.
REQ-021 MISS: mem_req and mem_addr held constant until mem_done or jump_flag; if_valid/if_pc ignored.
REQ-022 MISS, mem_done=1, no jump_flag: same edge write line (valid=1, tag, data=mem_inst), mem_req=0, inst_valid=1, inst_out=mem_inst, inst_pc=latched pc; go IDLE.
REQ-023 mem_req shall be 0 the cycle after mem_done is sampled, so the controller does not restart a fetch.
REQ-024 mem_done while IDLE shall be ignored (no write, no output).
REQ-025 jump_flag=1 in any state: next edge inst_valid=0, mem_req=0, state IDLE; requests in that cycle discarded.
REQ-026 jump_flag and mem_done in same cycle in MISS: line still written (data correct for that address), inst_valid=0.
REQ-027 inst_valid is 1 for exactly one cycle per served request; 0 otherwise.
REQ-028 New request accepted in IDLE the cycle inst_valid is high; back-to-back hits give one instruction per cycle.
REQ-029 rdy=0: no state, array or output change; inst_valid forced 0 on that edge; pending MISS resumes when rdy returns.
REQ-030 Data/tag arrays not reset; only valid bits cleared.

Reset
REQ-031 rst=0 asynchronously: state IDLE, all valid bits 0, inst_valid=0, mem_req=0, inst_out=0, inst_pc=0, mem_addr=0.
REQ-032 Reset mid-MISS: mem_req drops immediately; no line written; after release first fetch of any pc misses.
REQ-033 Leaving reset: first request accepted on first rising edge with rst=1 and rdy=1.

Verification
REQ-034 Cold miss: reset, if_valid pc=0x00000000, mem_done with mem_inst=0x00000013 four cycles later -> mem_req 1 then 0, inst_valid one cycle, inst_out=0x00000013, inst_pc=0.
REQ-035 Hit: repeat pc=0 -> inst_valid next cycle, inst_out=0x00000013, mem_req stays 0.
REQ-036 Conflict: fill pc=0x00000400 (same index, ICACHE_IDX_W=8), then pc=0 -> miss, mem_addr=0x00000000, refill.
REQ-037 Flush: miss pc=0x00001000, jump_flag pulse two cycles later -> mem_req 0 next cycle, no inst_valid; late mem_done ignored; new pc=0x00000004 accepted.
REQ-038 Jump+done same cycle: pc=0x00000008 miss, mem_done and jump_flag together with 0xDEADBEEF -> inst_valid 0; refetch 0x00000008 hits with 0xDEADBEEF.
REQ-039 rdy stall: rdy=0 for 3 cycles during MISS -> mem_req, mem_addr held; completion after rdy=1 as REQ-022.

Source files
------------

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped, one-word-per-line instruction cache
// Single outstanding miss; refill and response happen on the same edge as mem_done.
module icache #(
  parameter int ICACHE_IDX_W = 8,
  parameter int ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_pc,
  output logic              inst_valid,
  output logic [31:0]       inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_done,
  input  logic [31:0]       mem_inst,
  input  logic              jump_flag
);

  localparam int LINES = 1 << ICACHE_IDX_W;
  localparam int TAG_W = ADDR_W - ICACHE_IDX_W - 2;

  typedef enum logic {IDLE, MISS} state_t;

  state_t                   state, state_nx;
  logic [LINES-1:0]         valid;
  logic [TAG_W-1:0]         tag_arr  [LINES];
  logic [31:0]              data_arr [LINES];

  logic [ICACHE_IDX_W-1:0]  req_idx, fill_idx;
  logic [TAG_W-1:0]         req_tag, fill_tag;
  logic                     hit, fill;
  logic                     inst_valid_nx, mem_req_nx;
  logic [31:0]              inst_out_nx;
  logic [ADDR_W-1:0]        inst_pc_nx, mem_addr_nx;
  logic                     unused_offset;

  assign unused_offset = ^if_pc[1:0];
  assign req_idx  = if_pc[ICACHE_IDX_W+1:2];
  assign req_tag  = if_pc[ADDR_W-1:ICACHE_IDX_W+2];
  // mem_addr doubles as the latched miss pc while in MISS
  assign fill_idx = mem_addr[ICACHE_IDX_W+1:2];
  assign fill_tag = mem_addr[ADDR_W-1:ICACHE_IDX_W+2];
  assign hit      = valid[req_idx] && (tag_arr[req_idx] == req_tag);
  // A refill completes even when a flush arrives on the same cycle
  assign fill     = rdy && (state == MISS) && mem_done;

  always_comb begin
    state_nx      = state;
    inst_valid_nx = 1'b0;
    inst_out_nx   = inst_out;
    inst_pc_nx    = inst_pc;
    mem_req_nx    = mem_req;
    mem_addr_nx   = mem_addr;
    if (rdy) begin
      if (jump_flag) begin
        state_nx   = IDLE;
        mem_req_nx = 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (if_valid) begin
              if (hit) begin
                inst_valid_nx = 1'b1;
                inst_out_nx   = data_arr[req_idx];
                inst_pc_nx    = if_pc;
              end else begin
                state_nx    = MISS;
                mem_req_nx  = 1'b1;
                mem_addr_nx = if_pc;
              end
            end
          end
          MISS: begin
            if (mem_done) begin
              state_nx      = IDLE;
              mem_req_nx    = 1'b0;
              inst_valid_nx = 1'b1;
              inst_out_nx   = mem_inst;
              inst_pc_nx    = mem_addr;
            end
          end
          default: state_nx = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      valid      <= '0;
      inst_valid <= 1'b0;
      inst_out   <= '0;
      inst_pc    <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
    end else begin
      state      <= state_nx;
      inst_valid <= inst_valid_nx;
      inst_out   <= inst_out_nx;
      inst_pc    <= inst_pc_nx;
      mem_req    <= mem_req_nx;
      mem_addr   <= mem_addr_nx;
      if (fill) valid[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      tag_arr[fill_idx]  <= fill_tag;
      data_arr[fill_idx] <= mem_inst;
    end
  end

endmodule
